// File: rtl/cache_types.sv
// Shared L2 cache types and width defaults.
// Contents:
//   DEFAULT_LINE_WIDTH / DEFAULT_BEAT_WIDTH - line and bmem beat widths used as
//                                             parameter defaults by L2 blocks
//   responder_state_t                       - DFP responder FSM encoding
package cache_types;

    localparam int DEFAULT_LINE_WIDTH = 256;
    localparam int DEFAULT_BEAT_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WRITE_BURST = 3'd1,
        READ_REQ    = 3'd2,
        READ_BURST  = 3'd3,
        RESP        = 3'd4
    } responder_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide staging register shared by write drain and read fill.
// Ports:
//   clk, rst    - clock, async active-high reset (clears the line)
//   load        - capture load_line whole (write acceptance)
//   load_line   - full line to capture
//   beat_we     - write beat_in into slice beat_idx (read fill)
//   beat_idx    - beat index for both the write port and the read mux
//   beat_in     - beat to write
//   beat_out    - slice beat_idx of the current line (write drain)
//   line_next   - line value after this cycle's load/beat write
module line_beat_buffer
    import cache_types::*;
#(
    parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
    parameter int BEAT_WIDTH = DEFAULT_BEAT_WIDTH,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LINE_WIDTH-1:0] load_line,
    input  logic                  beat_we,
    input  logic [IDX_WIDTH-1:0]  beat_idx,
    input  logic [BEAT_WIDTH-1:0] beat_in,
    output logic [BEAT_WIDTH-1:0] beat_out,
    output logic [LINE_WIDTH-1:0] line_next
);

    logic [LINE_WIDTH-1:0] line_q;

    always_comb begin
        line_next = line_q;
        if (load) begin
            line_next = load_line;
        end else if (beat_we) begin
            line_next[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] = beat_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_next;
        end
    end

    assign beat_out = line_q[beat_idx*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/l2cache_dfp_responder.sv
// L2 downstream-port responder: turns a held whole-line read/write request into
// a fixed-length beat burst on the bmem interface and pulses dfp_resp on completion.
// Ports:
//   clk, rst                        - clock, async active-high reset
//   dfp_addr/read/write/wdata       - line request from the L2 controller (held until dfp_resp)
//   dfp_rdata, dfp_resp             - completed read line, one-cycle completion pulse
//   bmem_addr/read/write/wdata      - burst command / write beats toward memory
//   bmem_ready                      - memory accepts command or beat this cycle
//   bmem_rdata, bmem_rvalid         - read beats from memory
//
// state       | meaning
// IDLE        | waiting for dfp_write (priority) or dfp_read
// WRITE_BURST | driving write beats, advancing on bmem_ready
// READ_REQ    | holding the read command until bmem_ready
// READ_BURST  | collecting rvalid beats into the line buffer
// RESP        | one-cycle dfp_resp, then IDLE
module l2cache_dfp_responder
    import cache_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
    parameter int BEAT_WIDTH = DEFAULT_BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int BEATS     = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_WIDTH-1:0]  LAST_BEAT = CNT_WIDTH'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

    responder_state_t      state;
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] rdata_q;

    logic                  last_beat;
    logic                  accept_write;
    logic                  fill_beat;
    logic [LINE_WIDTH-1:0] line_next;
    logic [BEAT_WIDTH-1:0] beat_out;

    assign last_beat    = (beat_cnt == LAST_BEAT);
    assign accept_write = (state == IDLE) && dfp_write;
    // Beats arriving outside READ_BURST must not touch the buffer: during a
    // write it still holds the line being drained.
    assign fill_beat    = (state == READ_BURST) && bmem_rvalid;

    line_beat_buffer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .IDX_WIDTH  (CNT_WIDTH)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_write),
        .load_line (dfp_wdata),
        .beat_we   (fill_beat),
        .beat_idx  (beat_cnt),
        .beat_in   (bmem_rdata),
        .beat_out  (beat_out),
        .line_next (line_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dfp_write) begin
                        addr_q   <= dfp_addr & LINE_MASK;
                        beat_cnt <= '0;
                        state    <= WRITE_BURST;
                    end else if (dfp_read) begin
                        addr_q   <= dfp_addr & LINE_MASK;
                        beat_cnt <= '0;
                        state    <= READ_REQ;
                    end
                end
                WRITE_BURST: begin
                    if (bmem_ready) begin
                        if (last_beat) begin
                            state <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                READ_REQ: begin
                    if (bmem_ready) begin
                        state <= READ_BURST;
                    end
                end
                READ_BURST: begin
                    if (bmem_rvalid) begin
                        if (last_beat) begin
                            // Capture the completed line so dfp_rdata holds
                            // steady while later bursts reuse the buffer.
                            rdata_q <= line_next;
                            state   <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dfp_resp   = (state == RESP);
    assign dfp_rdata  = rdata_q;
    assign bmem_read  = (state == READ_REQ);
    assign bmem_write = (state == WRITE_BURST);
    assign bmem_addr  = addr_q;
    assign bmem_wdata = beat_out;

endmodule

// File: tb/tb_l2cache_dfp_responder.sv
// Directed bench for l2cache_dfp_responder: write/read bursts, ready stalls,
// rvalid gaps, write priority, back-to-back transactions, async reset, stray rvalid.
module tb_l2cache_dfp_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int n_chk  = 0;
    int n_pass = 0;
    int n_resp = 0;
    int n_rcmd = 0;
    int mark;

    logic [255:0] last_line;
    int exp_beat [7] = '{0, 1, 2, 2, 2, 2, 3};

    always #5 clk = ~clk;

    l2cache_dfp_responder dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (dfp_resp)  n_resp = n_resp + 1;
            if (bmem_read) n_rcmd = n_rcmd + 1;
        end
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_line(input logic [63:0] b0, input logic [63:0] b1,
                                            input logic [63:0] b2, input logic [63:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b1; bmem_rdata = '0; bmem_rvalid = 1'b0;
        tick(); tick();
        check_val("rst dfp_resp",   dfp_resp,   0);
        check_val("rst bmem_read",  bmem_read,  0);
        check_val("rst bmem_write", bmem_write, 0);
        check_val("rst bmem_addr",  bmem_addr,  0);
        check_val("rst dfp_rdata",  dfp_rdata,  0);
        check_val("rst bmem_wdata", bmem_wdata, 0);
        rst = 1'b0;
        tick();

        // Basic write: beats 0..3, address aligned down to 0x1220, resp at cycle 5
        dfp_addr  = 32'h0000_1234;
        dfp_wdata = mk_line(64'd0, 64'd1, 64'd2, 64'd3);
        dfp_write = 1'b1;
        tick();
        dfp_addr  = 32'hFFFF_FFC0;
        dfp_wdata = '1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            check_val("wr1 bmem_write", bmem_write, 1);
            check_val("wr1 bmem_addr",  bmem_addr,  32'h0000_1220);
            check_val("wr1 bmem_wdata", bmem_wdata, k);
            check_val("wr1 early resp", dfp_resp,   0);
        end
        tick();
        check_val("wr1 resp c5", dfp_resp, 1);
        dfp_write = 1'b0;
        tick();
        check_val("wr1 resp pulse", dfp_resp,   0);
        check_val("wr1 write done", bmem_write, 0);

        // Read with rvalid gap after beat 1: resp at cycle 7
        mark = n_rcmd;
        dfp_addr = 32'h8000_0040;
        dfp_read = 1'b1;
        tick();
        check_val("rd1 bmem_read", bmem_read, 1);
        check_val("rd1 bmem_addr", bmem_addr, 32'h8000_0040);
        tick();
        check_val("rd1 cmd one cycle", bmem_read, 0);
        bmem_rvalid = 1'b1; bmem_rdata = 64'hA;
        tick(); bmem_rdata = 64'hB;
        tick(); bmem_rvalid = 1'b0;
        tick(); bmem_rvalid = 1'b1; bmem_rdata = 64'hC;
        tick(); bmem_rdata = 64'hD;
        tick(); bmem_rvalid = 1'b0;
        check_val("rd1 resp c7", dfp_resp, 1);
        check_val("rd1 rdata", dfp_rdata, mk_line(64'hA, 64'hB, 64'hC, 64'hD));
        check_val("rd1 cmd count", n_rcmd - mark, 1);
        dfp_read = 1'b0;
        tick();
        check_val("rd1 resp pulse", dfp_resp, 0);
        check_val("rd1 rdata held", dfp_rdata, mk_line(64'hA, 64'hB, 64'hC, 64'hD));

        // Write with ready low for 3 cycles on beat 2: resp at cycle 8
        dfp_addr  = 32'h0000_2000;
        dfp_wdata = mk_line(64'h100, 64'h101, 64'h102, 64'h103);
        dfp_write = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            bmem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            check_val("wr2 bmem_write", bmem_write, 1);
            check_val("wr2 bmem_wdata", bmem_wdata, 64'h100 + exp_beat[c-1]);
        end
        tick();
        check_val("wr2 resp c8", dfp_resp, 1);
        dfp_write = 1'b0;
        bmem_ready = 1'b1;
        tick();

        // Read and write both high: write first, then read accepted after resp
        mark = n_rcmd;
        dfp_addr  = 32'h0000_3000;
        dfp_wdata = mk_line(64'h200, 64'h201, 64'h202, 64'h203);
        dfp_write = 1'b1;
        dfp_read  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("both bmem_write", bmem_write, 1);
            check_val("both bmem_wdata", bmem_wdata, 64'h200 + k);
        end
        tick();
        check_val("both resp c5", dfp_resp, 1);
        check_val("both no read cmd", n_rcmd - mark, 0);
        dfp_write = 1'b0;
        tick();
        check_val("b2b idle no cmd", bmem_read, 0);
        tick();
        check_val("b2b bmem_read", bmem_read, 1);
        check_val("b2b bmem_addr", bmem_addr, 32'h0000_3000);
        tick(); bmem_rvalid = 1'b1; bmem_rdata = 64'h11;
        tick(); bmem_rdata = 64'h22;
        tick(); bmem_rdata = 64'h33;
        tick(); bmem_rdata = 64'h44;
        tick(); bmem_rvalid = 1'b0;
        check_val("b2b resp", dfp_resp, 1);
        check_val("b2b rdata", dfp_rdata, mk_line(64'h11, 64'h22, 64'h33, 64'h44));
        dfp_read = 1'b0;
        tick();

        // Async reset after beat 1 of a read
        dfp_addr = 32'h0000_4000;
        dfp_read = 1'b1;
        tick();
        tick(); bmem_rvalid = 1'b1; bmem_rdata = 64'h55;
        tick(); bmem_rdata = 64'h66;
        tick(); bmem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        check_val("arst bmem_read",  bmem_read,  0);
        check_val("arst bmem_write", bmem_write, 0);
        check_val("arst dfp_resp",   dfp_resp,   0);
        check_val("arst bmem_addr",  bmem_addr,  0);
        check_val("arst dfp_rdata",  dfp_rdata,  0);
        check_val("arst bmem_wdata", bmem_wdata, 0);
        dfp_read = 1'b0;
        mark = n_resp;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_val("arst no resp", n_resp - mark, 0);

        dfp_addr = 32'h0000_0100;
        dfp_read = 1'b1;
        tick();
        check_val("post-rst bmem_read", bmem_read, 1);
        check_val("post-rst bmem_addr", bmem_addr, 32'h0000_0100);
        tick(); bmem_rvalid = 1'b1; bmem_rdata = 64'h71;
        tick(); bmem_rdata = 64'h72;
        tick(); bmem_rdata = 64'h73;
        tick(); bmem_rdata = 64'h74;
        tick(); bmem_rvalid = 1'b0;
        check_val("post-rst resp", dfp_resp, 1);
        last_line = mk_line(64'h71, 64'h72, 64'h73, 64'h74);
        check_val("post-rst rdata", dfp_rdata, last_line);
        dfp_read = 1'b0;
        tick();

        // Stray rvalid while idle and during a write
        mark = n_resp;
        bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD_BEEF;
        tick(); tick();
        bmem_rvalid = 1'b0;
        check_val("stray idle rdata", dfp_rdata, last_line);
        check_val("stray idle read",  bmem_read, 0);
        check_val("stray idle write", bmem_write, 0);
        check_val("stray idle resp",  n_resp - mark, 0);
        dfp_addr  = 32'h0000_5000;
        dfp_wdata = mk_line(64'h300, 64'h301, 64'h302, 64'h303);
        dfp_write = 1'b1;
        bmem_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("stray wr wdata", bmem_wdata, 64'h300 + k);
        end
        tick();
        check_val("stray wr resp",  dfp_resp,  1);
        check_val("stray wr rdata", dfp_rdata, last_line);
        dfp_write = 1'b0;
        bmem_rvalid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/l2cache_dfp_responder.md
# l2cache_dfp_responder

Memory-side responder for the L2 cache's downstream-facing port (DFP). Accepts a whole-line read or write held by the L2 controller (`dfp_read` / `dfp_write` asserted until `dfp_resp`). Serialises the line into a fixed-length beat burst on the burst-memory (bmem) interface, and pulses `dfp_resp` once the transfer completes. Sits between `l2cache_control` / `l2cache` datapath and the main-memory model or DRAM controller.

## Interface
- `ADDR_WIDTH`, 32, byte-address width.
- `LINE_WIDTH`, 256, cache-line width in bits.
- `BEAT_WIDTH`, 64, bmem data-beat width. `LINE_WIDTH` must be an integer multiple; `BEATS = LINE_WIDTH/BEAT_WIDTH` (default 4).

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `dfp_addr`  in  ADDR_WIDTH  line address; low log2(LINE_WIDTH/8) bits ignored.
- `dfp_read`  in  1  line-read request, held until `dfp_resp`.
- `dfp_write`  in  1  line-write request, held until `dfp_resp`.
- `dfp_wdata`  in  LINE_WIDTH  write line; sampled at acceptance only.
- `dfp_rdata`  out  LINE_WIDTH  read line; valid in the `dfp_resp` cycle, held until the next read completes.
- `dfp_resp`  out  1  one-cycle completion pulse.
- `bmem_addr`  out  ADDR_WIDTH  line-aligned burst address; valid while `bmem_read` or `bmem_write` is high.
- `bmem_read`  out  1  read-burst command; one accepted cycle per burst.
- `bmem_write`  out  1  write-beat valid; high for every write beat.
- `bmem_wdata`  out  BEAT_WIDTH  current write beat.
- `bmem_ready`  in  1  memory accepts the command or beat this cycle.
- `bmem_rdata`  in  BEAT_WIDTH  read beat.
- `bmem_rvalid`  in  1  `bmem_rdata` valid this cycle.

## Operation
- States: IDLE, WRITE_BURST, READ_REQ, READ_BURST, RESP.
- IDLE:
  - `dfp_write` → latch the aligned address and `dfp_wdata`, clear the beat counter, go to WRITE_BURST.
  - Otherwise `dfp_read` → latch the aligned address, clear the counter, go to READ_REQ.
  - Write wins if both are high.
- WRITE_BURST:
  - `bmem_write`=1, `bmem_addr`=latched address, `bmem_wdata`=line slice [counter*BEAT_WIDTH +: BEAT_WIDTH] (beat 0 = LSBs).
  - The counter increments only when `bmem_ready`=1.
  - On the ready cycle of beat BEATS-1 → RESP.
- READ_REQ: `bmem_read`=1 with the address; on `bmem_ready` → READ_BURST.
- READ_BURST:
  - Each `bmem_rvalid` cycle writes `bmem_rdata` into slice [counter] of the read buffer and increments the counter.
  - On beat BEATS-1 → RESP.
  - Gaps in `rvalid` are legal.
- RESP: `dfp_resp`=1 for exactly one cycle, then IDLE. `dfp_rdata` is driven from the read buffer.
- `bmem_rvalid` outside READ_BURST is ignored (buffer unchanged).
- `dfp_read` / `dfp_write` seen in the cycle after RESP (IDLE) start a new transaction. This supports back-to-back writeback→fetch.
- The beat counter is log2(BEATS) bits, or 1 bit if BEATS=1. The counter is compared against BEATS-1 and never wraps mid-burst.
- Reset:
  - Asynchronous; state goes to IDLE.
  - `dfp_resp`, `bmem_read`, `bmem_write` go to 0.
  - Counter, read buffer, `dfp_rdata`, `bmem_addr`, `bmem_wdata` go to 0.
  - Any in-flight burst is abandoned; no `dfp_resp` is issued for it.

## Timing
- `dfp_resp` is registered; all bmem outputs are decoded from registered state and are glitch-free relative to the DFP inputs.
- Write, with `bmem_ready` always high: accept at cycle 0; beats on cycles 1..BEATS; `dfp_resp` at cycle BEATS+1 (5 by default).
- Read, with ready always high and rvalid on consecutive cycles starting the cycle after the command: accept at 0; `bmem_read` at 1; beats at 2..BEATS+1; `dfp_resp` at BEATS+2 (6 by default).
- Each `bmem_ready`=0 cycle extends the write or read-command phase by one cycle. Each `rvalid` gap extends READ_BURST by one cycle.
- `dfp_addr` and `dfp_wdata` changes after acceptance have no effect.

## Structure
- Add `responder_state_t` (IDLE, WRITE_BURST, READ_REQ, READ_BURST, RESP) to `cache_types`, beside `controller_state_t`. Add the shared LINE_WIDTH/BEAT_WIDTH defaults there too.
- One sub-module: `line_beat_buffer`. It holds the LINE_WIDTH register, a beat-indexed write port (read fill) and a beat-indexed read mux (write drain), all driven by the responder's counter.
- The FSM, counter and address latch stay in `l2cache_dfp_responder`.

## Test plan
- Write line 0x…0003_0002_0001_0000 (beat k = k) to address 0x0000_1234, ready tied high → `bmem_addr`=0x0000_1220 on 4 consecutive `bmem_write` cycles with `wdata` 0,1,2,3; `dfp_resp` pulses once at cycle 5.
- Read from 0x8000_0040 with a memory model returning beats 0xA..0xD, rvalid gap after beat 1 → `bmem_read` for one cycle; `dfp_rdata`={0xD,0xC,0xB,0xA} at `dfp_resp`, cycle 7.
- `bmem_ready` low for 3 cycles during write beat 2 → beat 2 held stable for 4 cycles; `dfp_resp` at cycle 8.
- `dfp_read` and `dfp_write` both high → write burst only, no `bmem_read`. Then the controller issues a read the cycle after `dfp_resp` → accepted immediately, read burst follows.
- `rst` asserted asynchronously mid-read (after beat 1) → outputs zero before the next edge. No `dfp_resp`. A subsequent read completes normally with fresh data.
- Stray `bmem_rvalid` pulses while IDLE and during a write → `dfp_rdata` unchanged, no state change.
